// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB plus an
// iterative MULDIV wait and a sticky TRAP state for undefined instructions.
module multicycle_control_unit #(
  parameter int MULDIV_LATENCY = 32,
  parameter int ALUOP_W        = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zero,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               i_or_d,
  output logic               ir_we,
  output logic               pc_we,
  output logic [1:0]         pc_src,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               reg_we,
  output logic [1:0]         write_dest,
  output logic [2:0]         write_data,
  output logic               muldiv_start,
  output logic               muldiv_op,
  output logic               we_hilo,
  output logic               busy,
  output logic               illegal
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_MULDIV, S_TRAP
  } state_t;

  typedef enum logic [3:0] {
    C_ALU, C_ADDI, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL,
    C_MFHI, C_MFLO, C_MULT, C_DIV, C_ILL
  } cls_t;

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4);
  localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(5);
  localparam logic [7:0]         CNT_LOAD = 8'(MULDIV_LATENCY - 1);

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               illegal_q;
  cls_t               cls;
  logic [ALUOP_W-1:0] alu_r;

  // Instruction class from IR fields; valid from DECODE onward.
  always_comb begin
    cls   = C_ILL;
    alu_r = ALU_ADD;
    case (opcode)
      6'b000000: begin
        case (funct)
          6'b100000: begin cls = C_ALU; alu_r = ALU_ADD; end
          6'b100010: begin cls = C_ALU; alu_r = ALU_SUB; end
          6'b100100: begin cls = C_ALU; alu_r = ALU_AND; end
          6'b100101: begin cls = C_ALU; alu_r = ALU_OR;  end
          6'b101010: begin cls = C_ALU; alu_r = ALU_SLT; end
          6'b000000: begin cls = C_ALU; alu_r = ALU_SLL; end
          6'b011000: cls = C_MULT;
          6'b011010: cls = C_DIV;
          6'b010000: cls = C_MFHI;
          6'b010010: cls = C_MFLO;
          default:   cls = C_ILL;
        endcase
      end
      6'b001000: cls = C_ADDI;
      6'b100011: cls = C_LW;
      6'b101011: cls = C_SW;
      6'b000100: cls = C_BEQ;
      6'b000101: cls = C_BNE;
      6'b000010: cls = C_J;
      6'b000011: cls = C_JAL;
      default:   cls = C_ILL;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_FETCH:  if (mem_ack) state_d = S_DECODE;
      S_DECODE: state_d = (cls == C_ILL) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (cls)
          C_ALU, C_ADDI: state_d = S_WB;
          C_LW, C_SW:    state_d = S_MEM;
          C_MULT, C_DIV: begin state_d = S_MULDIV; cnt_d = CNT_LOAD; end
          default:       state_d = S_FETCH;
        endcase
      end
      S_MEM:    if (mem_ack) state_d = (cls == C_LW) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_MULDIV: begin
        if (cnt_q == 8'd0) state_d = S_FETCH;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= 8'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_q | (state_d == S_TRAP);
    end
  end

  // Outputs decode the current state; reset forces the quiet all-zero pattern.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    i_or_d       = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = ALU_ADD;
    reg_we       = 1'b0;
    write_dest   = 2'b00;
    write_data   = 3'b000;
    muldiv_start = 1'b0;
    muldiv_op    = 1'b0;
    we_hilo      = 1'b0;
    busy         = 1'b0;
    illegal      = 1'b0;
    if (!reset) begin
      busy    = (state_q != S_FETCH);
      illegal = illegal_q;
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ack;
          pc_we   = mem_ack;
        end
        S_EXEC: begin
          case (cls)
            C_ALU: begin
              alu_op    = alu_r;
              alu_src_b = (alu_r == ALU_SLL) ? 2'b10 : 2'b00;
            end
            C_ADDI, C_LW, C_SW: alu_src_b = 2'b01;
            C_BEQ: begin alu_op = ALU_SUB; pc_src = 2'b10; pc_we = zero;  end
            C_BNE: begin alu_op = ALU_SUB; pc_src = 2'b10; pc_we = ~zero; end
            C_J:   begin pc_we = 1'b1; pc_src = 2'b01; end
            C_JAL: begin
              pc_we      = 1'b1;
              pc_src     = 2'b01;
              reg_we     = 1'b1;
              write_dest = 2'b10;
              write_data = 3'b010;
            end
            C_MFHI: begin reg_we = 1'b1; write_dest = 2'b01; write_data = 3'b011; end
            C_MFLO: begin reg_we = 1'b1; write_dest = 2'b01; write_data = 3'b100; end
            C_MULT: muldiv_start = 1'b1;
            C_DIV:  begin muldiv_start = 1'b1; muldiv_op = 1'b1; end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          i_or_d  = 1'b1;
          mem_we  = (cls == C_SW);
        end
        S_WB: begin
          reg_we     = 1'b1;
          write_dest = (cls == C_ALU) ? 2'b01 : 2'b00;
          write_data = (cls == C_LW) ? 3'b001 : 3'b000;
        end
        S_MULDIV: we_hilo = (cnt_q == 8'd0);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
module tb_multicycle_control_unit;

  typedef struct packed {
    logic       mem_req, mem_we, i_or_d, ir_we, pc_we;
    logic [1:0] pc_src, alu_src_b;
    logic [3:0] alu_op;
    logic       reg_we;
    logic [1:0] write_dest;
    logic [2:0] write_data;
    logic       muldiv_start, muldiv_op, we_hilo, busy, illegal;
  } out_t;

  logic       clock = 1'b0;
  logic       reset, zero, mem_ack;
  logic [5:0] opcode, funct;
  out_t       act;
  bit         done = 1'b0;

  multicycle_control_unit #(.MULDIV_LATENCY(4), .ALUOP_W(4)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ack(mem_ack),
    .mem_req(act.mem_req), .mem_we(act.mem_we), .i_or_d(act.i_or_d),
    .ir_we(act.ir_we), .pc_we(act.pc_we), .pc_src(act.pc_src),
    .alu_src_b(act.alu_src_b), .alu_op(act.alu_op), .reg_we(act.reg_we),
    .write_dest(act.write_dest), .write_data(act.write_data),
    .muldiv_start(act.muldiv_start), .muldiv_op(act.muldiv_op),
    .we_hilo(act.we_hilo), .busy(act.busy), .illegal(act.illegal)
  );

  always #5 clock = ~clock;

  out_t  exp_q[$];
  string name_q[$];
  int    n_run = 0, n_fail = 0;

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      out_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      n_run++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", n, act, e);
      end
    end
  end

  initial begin
    #20000;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: wait expired with %0d expectations pending", exp_q.size());
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
    end
  end

  function automatic out_t z();
    z = '0;
  endfunction
  function automatic out_t fetch(logic ack);
    fetch = '0; fetch.mem_req = 1; fetch.ir_we = ack; fetch.pc_we = ack;
  endfunction
  function automatic out_t bsy();
    bsy = '0; bsy.busy = 1;
  endfunction
  function automatic out_t mem(logic we);
    mem = bsy(); mem.mem_req = 1; mem.i_or_d = 1; mem.mem_we = we;
  endfunction
  function automatic out_t wb(logic [1:0] d, logic [2:0] s);
    wb = bsy(); wb.reg_we = 1; wb.write_dest = d; wb.write_data = s;
  endfunction
  function automatic out_t ex_alu(logic [3:0] op, logic [1:0] b);
    ex_alu = bsy(); ex_alu.alu_op = op; ex_alu.alu_src_b = b;
  endfunction
  function automatic out_t ex_br(logic taken);
    ex_br = bsy(); ex_br.alu_op = 4'd1; ex_br.pc_src = 2'b10; ex_br.pc_we = taken;
  endfunction

  task automatic step(input logic r, input logic z_in, input logic ack,
                      input out_t e, input string n);
    reset   = r;
    zero    = z_in;
    mem_ack = ack;
    exp_q.push_back(e);
    name_q.push_back(n);
    @(posedge clock); #1;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask

  initial begin
    out_t e;
    reset = 1; zero = 0; mem_ack = 1; opcode = '0; funct = '0;
    @(posedge clock); #1;
    n_run++;
    if (act !== out_t'('0)) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected all zero", act);
    end
    mem_ack = 0;
    step(1, 0, 1, z(), "reset_quiet0");
    step(1, 0, 1, z(), "reset_quiet1");

    instr(6'b000000, 6'b100000);
    step(0, 0, 0, fetch(0), "add_fetch_wait");
    step(0, 0, 1, fetch(1), "add_fetch_ack");
    step(0, 0, 1, bsy(),    "add_decode_ack_ignored");
    step(0, 0, 0, ex_alu(4'd0, 2'b00), "add_exec");
    step(0, 0, 0, wb(2'b01, 3'b000),   "add_wb");

    instr(6'b000000, 6'b000000);
    step(0, 0, 1, fetch(1), "sll_fetch");
    step(0, 0, 0, bsy(),    "sll_decode");
    step(0, 0, 0, ex_alu(4'd5, 2'b10), "sll_exec");
    step(0, 0, 0, wb(2'b01, 3'b000),   "sll_wb");

    instr(6'b100011, 6'b000000);
    step(0, 0, 1, fetch(1), "lw_fetch");
    step(0, 0, 0, bsy(),    "lw_decode");
    step(0, 0, 0, ex_alu(4'd0, 2'b01), "lw_exec");
    for (int i = 0; i < 3; i++) step(0, 0, 0, mem(0), "lw_mem_wait");
    step(0, 0, 1, mem(0), "lw_mem_ack");
    step(0, 0, 0, wb(2'b00, 3'b001), "lw_wb");

    instr(6'b101011, 6'b000000);
    step(0, 0, 1, fetch(1), "sw_fetch");
    step(0, 0, 0, bsy(),    "sw_decode");
    step(0, 0, 0, ex_alu(4'd0, 2'b01), "sw_exec");
    step(0, 0, 1, mem(1),   "sw_mem_ack");

    instr(6'b001000, 6'b000000);
    step(0, 0, 1, fetch(1), "addi_fetch");
    step(0, 0, 0, bsy(),    "addi_decode");
    step(0, 0, 0, ex_alu(4'd0, 2'b01), "addi_exec");
    step(0, 0, 0, wb(2'b00, 3'b000),   "addi_wb");

    instr(6'b000100, 6'b000000);
    step(0, 0, 1, fetch(1), "beq1_fetch");
    step(0, 0, 0, bsy(),    "beq1_decode");
    step(0, 1, 0, ex_br(1), "beq_zero1_taken");
    step(0, 0, 1, fetch(1), "beq0_fetch");
    step(0, 0, 0, bsy(),    "beq0_decode");
    step(0, 0, 0, ex_br(0), "beq_zero0_not_taken");
    instr(6'b000101, 6'b000000);
    step(0, 0, 1, fetch(1), "bne_fetch");
    step(0, 0, 0, bsy(),    "bne_decode");
    step(0, 0, 0, ex_br(1), "bne_zero0_taken");

    instr(6'b000011, 6'b000000);
    step(0, 0, 1, fetch(1), "jal_fetch");
    step(0, 0, 0, bsy(),    "jal_decode");
    e = bsy(); e.pc_we = 1; e.pc_src = 2'b01; e.reg_we = 1;
    e.write_dest = 2'b10; e.write_data = 3'b010;
    step(0, 0, 0, e, "jal_exec");

    instr(6'b000000, 6'b010010);
    step(0, 0, 1, fetch(1), "mflo_fetch");
    step(0, 0, 0, bsy(),    "mflo_decode");
    e = bsy(); e.reg_we = 1; e.write_dest = 2'b01; e.write_data = 3'b100;
    step(0, 0, 0, e, "mflo_exec");

    instr(6'b000000, 6'b011000);
    step(0, 0, 1, fetch(1), "mult_fetch");
    step(0, 0, 0, bsy(),    "mult_decode");
    e = bsy(); e.muldiv_start = 1;
    step(0, 0, 0, e, "mult_exec_start");
    for (int i = 0; i < 3; i++) step(0, 0, 0, bsy(), "mult_wait");
    e = bsy(); e.we_hilo = 1;
    step(0, 0, 0, e, "mult_we_hilo");
    step(0, 0, 0, fetch(0), "mult_back_to_fetch");

    instr(6'b000000, 6'b011010);
    step(0, 0, 1, fetch(1), "div_fetch");
    step(0, 0, 0, bsy(),    "div_decode");
    e = bsy(); e.muldiv_start = 1; e.muldiv_op = 1;
    step(0, 0, 0, e, "div_exec_start");
    step(0, 0, 0, bsy(), "div_wait1");
    step(1, 0, 0, z(),   "div_reset_cycle");
    for (int i = 0; i < 4; i++) step(0, 0, 0, fetch(0), "div_after_reset_fetch");

    instr(6'b111111, 6'b000000);
    step(0, 0, 1, fetch(1), "ill_fetch");
    step(0, 0, 0, bsy(),    "ill_decode");
    e = bsy(); e.illegal = 1;
    for (int i = 0; i < 20; i++) step(0, i[0], i[1], e, "ill_trap_hold");
    step(1, 0, 0, z(), "ill_reset");
    instr(6'b000000, 6'b100000);
    step(0, 0, 0, fetch(0), "ill_cleared_fetch");

    @(negedge clock);
    @(posedge clock); #1;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations never compared", exp_q.size());
    end
    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
